// File: rtl/text_buffer_ctrl.sv
// Character line buffer for the VGA text renderer: CPU command handshake, write cursor, clear fill.
// Define VBLANK_SYNC_EN to accept commands only during vertical blanking.
module text_buffer_ctrl #(
    parameter int          DEPTH     = 256,
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    localparam int         CUR_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic             vblank,
    output logic [7:0]       text [DEPTH],
    output logic [CUR_W-1:0] cursor,
    output logic             busy
);

    // state    | meaning
    // ST_IDLE  | accepting commands (subject to the vblank gate)
    // ST_CLEAR | sweeping FILL_CHAR across every cell, one per cycle
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_SETCUR    = 2'd1;
    localparam logic [1:0] OP_BACKSPACE = 2'd2;
    localparam logic [1:0] OP_CLEAR     = 2'd3;

    localparam logic [CUR_W-1:0] LAST_IDX = CUR_W'(DEPTH - 1);

    logic [0:0]       state;
    logic [0:0]       nextState;
    logic [CUR_W-1:0] idx;
    logic [CUR_W-1:0] nextIdx;
    logic [CUR_W-1:0] nextCursor;
    logic             gate;
    logic             accept;
    logic             wrEn;
    logic [CUR_W-1:0] wrAddr;
    logic [7:0]       wrData;

`ifdef VBLANK_SYNC_EN
    assign gate = vblank;
`else
    logic unusedVblank;
    assign unusedVblank = vblank;
    assign gate = 1'b1;
`endif

    assign cmd_ready = (state == ST_IDLE) && gate;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == ST_CLEAR);

    always_comb begin
        nextState  = state;
        nextIdx    = idx;
        nextCursor = cursor;
        wrEn       = 1'b0;
        wrAddr     = '0;
        wrData     = FILL_CHAR;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wrEn       = 1'b1;
                            wrAddr     = cursor;
                            wrData     = cmd_data;
                            nextCursor = cursor + CUR_W'(1);
                        end
                        OP_SETCUR: begin
                            nextCursor = cmd_data[CUR_W-1:0];
                        end
                        OP_BACKSPACE: begin
                            // saturates at cell 0 rather than wrapping to the end of the line
                            if (cursor != '0) begin
                                nextCursor = cursor - CUR_W'(1);
                                wrEn       = 1'b1;
                                wrAddr     = cursor - CUR_W'(1);
                            end
                        end
                        OP_CLEAR: begin
                            nextState  = ST_CLEAR;
                            nextIdx    = '0;
                            nextCursor = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                // runs to completion regardless of vblank once started
                wrEn    = 1'b1;
                wrAddr  = idx;
                nextIdx = idx + CUR_W'(1);
                if (idx == LAST_IDX) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cursor <= '0;
        end else begin
            state  <= nextState;
            idx    <= nextIdx;
            cursor <= nextCursor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                text[i] <= FILL_CHAR;
            end
        end else if (wrEn) begin
            text[wrAddr] <= wrData;
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed self-checking bench for text_buffer_ctrl; build with VBLANK_SYNC_EN to cover the vblank gate.
module tb_text_buffer_ctrl;

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_SETCUR    = 2'd1;
    localparam logic [1:0] OP_BACKSPACE = 2'd2;
    localparam logic [1:0] OP_CLEAR     = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       vblank;
    logic [7:0] text [256];
    logic [7:0] cursor;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;

    text_buffer_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .vblank    (vblank),
        .text      (text),
        .cursor    (cursor),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int countNot(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            if (text[i] !== v) n++;
        end
        return n;
    endfunction

    // Presents a command at a falling edge, holds it until accepted, returns 1 time unit after the accept edge.
    task automatic sendCmd(input logic [1:0] op, input logic [7:0] data);
        int waitCyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        while (!cmd_ready && waitCyc < 1000) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        checkVal("accept_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    int busyCycles;
    int readyHigh;
    int guard;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h00;
`ifdef VBLANK_SYNC_EN
        vblank    = 1'b1;
`else
        vblank    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        checkVal("reset_text", countNot(8'h20), 0);
        checkVal("reset_cursor", cursor, 0);
        checkVal("reset_busy", busy, 0);
        checkVal("reset_ready", cmd_ready, 1);

        // back-to-back writes from cursor 0
        sendCmd(OP_WRITE, 8'h41);
        checkVal("wr_a_text0", text[0], 8'h41);
        checkVal("wr_a_cursor", cursor, 1);
        sendCmd(OP_WRITE, 8'h42);
        checkVal("wr_b_text1", text[1], 8'h42);
        checkVal("wr_b_cursor", cursor, 2);

        // cursor wrap at the end of the line
        sendCmd(OP_SETCUR, 8'hFF);
        checkVal("setcur_cursor", cursor, 8'hFF);
        checkVal("setcur_text_kept", text[1], 8'h42);
        sendCmd(OP_WRITE, 8'h5A);
        checkVal("wrap_text255", text[255], 8'h5A);
        checkVal("wrap_cursor", cursor, 0);
        sendCmd(OP_WRITE, 8'h31);
        checkVal("wrap_text0", text[0], 8'h31);
        checkVal("wrap_cursor1", cursor, 1);

        // backspace, then saturating backspace at 0
        sendCmd(OP_BACKSPACE, 8'h00);
        checkVal("bs_text0", text[0], 8'h20);
        checkVal("bs_cursor", cursor, 0);
        sendCmd(OP_BACKSPACE, 8'h00);
        checkVal("bs_sat_cursor", cursor, 0);
        checkVal("bs_sat_text1", text[1], 8'h42);
        checkVal("bs_sat_text255", text[255], 8'h5A);

        // fill every cell with 'A'
        sendCmd(OP_SETCUR, 8'h00);
        for (int i = 0; i < 256; i++) sendCmd(OP_WRITE, 8'h41);
        checkVal("fill_text", countNot(8'h41), 0);
        checkVal("fill_cursor", cursor, 0);

        // clear with a WRITE held throughout
        sendCmd(OP_SETCUR, 8'h07);
        sendCmd(OP_CLEAR, 8'h00);
        checkVal("clr_cursor0", cursor, 0);
        cmd_valid  = 1'b1;
        cmd_op     = OP_WRITE;
        cmd_data   = 8'h55;
        busyCycles = 0;
        readyHigh  = 0;
        guard      = 0;
        while (busy && guard < 400) begin
            if (cmd_ready) readyHigh++;
            if (busyCycles == 100) begin
                checkVal("clr_mid_done99", text[99], 8'h20);
                checkVal("clr_mid_old100", text[100], 8'h41);
            end
            busyCycles++;
            guard++;
            @(posedge clk);
            #1;
        end
        checkVal("clr_busy_cycles", busyCycles, 256);
        checkVal("clr_ready_low", readyHigh, 0);
        checkVal("clr_text", countNot(8'h20), 0);
        checkVal("clr_cursor", cursor, 0);
        checkVal("clr_ready_after", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkVal("held_wr_text0", text[0], 8'h55);
        checkVal("held_wr_cursor", cursor, 1);

        // reset while clearing
        for (int i = 0; i < 4; i++) sendCmd(OP_WRITE, 8'h41);
        sendCmd(OP_CLEAR, 8'h00);
        repeat (50) @(posedge clk);
        #1;
        checkVal("rstclr_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        checkVal("rstclr_busy", busy, 0);
        checkVal("rstclr_cursor", cursor, 0);
        checkVal("rstclr_text", countNot(8'h20), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("rstclr_ready", cmd_ready, 1);

`ifdef VBLANK_SYNC_EN
        // WRITE held outside blanking is refused until vblank rises
        vblank    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h41;
        readyHigh = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cmd_ready) readyHigh++;
            @(negedge clk);
        end
        checkVal("vb_ready_low", readyHigh, 0);
        checkVal("vb_text_kept", countNot(8'h20), 0);
        checkVal("vb_cursor_kept", cursor, 0);
        vblank = 1'b1;
        #1;
        checkVal("vb_ready_high", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkVal("vb_wr_text0", text[0], 8'h41);
        checkVal("vb_wr_cursor", cursor, 1);

        // clear keeps running after vblank falls
        sendCmd(OP_CLEAR, 8'h00);
        busyCycles = 0;
        guard      = 0;
        while (busy && guard < 400) begin
            busyCycles++;
            guard++;
            if (busyCycles == 5) vblank = 1'b0;
            @(posedge clk);
            #1;
        end
        checkVal("vb_clr_cycles", busyCycles, 256);
        checkVal("vb_clr_text", countNot(8'h20), 0);
        checkVal("vb_clr_ready_low", cmd_ready, 0);
`else
        // vblank is ignored: accepted with vblank low
        vblank = 1'b0;
        sendCmd(OP_WRITE, 8'h33);
        checkVal("novb_text0", text[0], 8'h33);
        checkVal("novb_cursor", cursor, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
